softmax_exp_sequencer: RTL

Collects one frame of NUM_CLASSES unsigned 8-bit class scores from the output layer and tracks the frame minimum during load. It then drives the combinational exp LUT (IEEE_754_expFunction, instantiated at the softmax top) once per class with the min-normalised, clamped index, and buffers the 32-bit IEEE-754 results. It streams the results to the softmax sum/divide stage over valid/ready. It is the sole master of the LUT address; the LUT sits outside this block.

---
 rtl/softmax_exp_sequencer_pkg.sv | 16 +
 rtl/softmax_exp_sequencer_if.sv | 26 ++
 rtl/softmax_exp_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/softmax_exp_sequencer_pkg.sv
// Shared types and constants for the softmax exp sequencer.
package softmax_exp_sequencer_pkg;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_EXP  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam int NUM_CLASSES_DEF = 10;
  localparam int LUT_MAX_DEF     = 10;

  localparam logic [31:0] FP32_ONE = 32'h3F80_0000;
  localparam logic [31:0] FP32_INF = 32'h7F80_0000;

endpackage

// File: rtl/softmax_exp_sequencer_if.sv
// Score-in / result-out stream bundle. The master modport is the sequencer
// side (consumes scores, produces results); slave is the surrounding logic.
interface softmax_exp_sequencer_if #(
  parameter int SCORE_W = 8
) ();

  logic               in_valid;
  logic               in_ready;
  logic [SCORE_W-1:0] in_score;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_exp;
  logic [3:0]         out_idx;
  logic               out_last;

  modport master (
    input  in_valid, in_score, out_ready,
    output in_ready, out_valid, out_exp, out_idx, out_last
  );

  modport slave (
    output in_valid, in_score, out_ready,
    input  in_ready, out_valid, out_exp, out_idx, out_last
  );

endinterface

// File: rtl/softmax_exp_sequencer.sv
// Loads one frame of class scores, walks the external exp LUT with the
// min-normalised clamped index, buffers the FP32 results and streams them out.
module softmax_exp_sequencer
  import softmax_exp_sequencer_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int SCORE_W     = 8,
  parameter int LUT_MAX     = LUT_MAX_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  softmax_exp_sequencer_if.master        bus,
  output logic [7:0]                     lut_x,
  input  logic [31:0]                    lut_exp,
  output logic                           busy,
  output logic                           sat_flag
);

  localparam logic [3:0] LAST = 4'(NUM_CLASSES - 1);

  state_t             state;
  logic [3:0]         cnt;
  logic [SCORE_W-1:0] min_r;
  logic [SCORE_W-1:0] score_buf [NUM_CLASSES];
  logic [31:0]        exp_buf   [NUM_CLASSES];
  logic [SCORE_W-1:0] diff_p0;
  logic               cap_vld_p1;
  logic [3:0]         cap_idx_p1;

  // Differences beyond the last finite LUT entry saturate to it.
  function automatic logic is_clamped(input logic [SCORE_W-1:0] d);
    return int'(d) > LUT_MAX;
  endfunction

  function automatic logic [7:0] clamp_idx(input logic [SCORE_W-1:0] d);
    return is_clamped(d) ? 8'(LUT_MAX) : 8'(d);
  endfunction

  // Stage p0: score minus frame minimum; never negative because min_r is the frame minimum.
  always_comb begin
    diff_p0 = score_buf[cnt] - min_r;
  end

  // Score buffer write on each accepted input beat (data only, no reset).
  always_ff @(posedge clk) begin
    if (state == S_LOAD && bus.in_valid && bus.in_ready) begin
      score_buf[cnt] <= bus.in_score;
    end
  end

  // Stage p1: LUT result for the address registered last cycle lands in exp_buf.
  always_ff @(posedge clk) begin
    if (cap_vld_p1) begin
      exp_buf[cap_idx_p1] <= lut_exp;
    end
  end

  // Control FSM: load / LUT walk / output stream, all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_LOAD;
      cnt           <= '0;
      min_r         <= '1;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_exp   <= '0;
      bus.out_idx   <= '0;
      busy          <= 1'b0;
      sat_flag      <= 1'b0;
      lut_x         <= '0;
      cap_vld_p1    <= 1'b0;
      cap_idx_p1    <= '0;
    end else begin
      cap_vld_p1 <= 1'b0;
      case (state)
        S_LOAD: begin
          if (bus.in_valid && bus.in_ready) begin
            if (cnt == '0) begin
              min_r    <= bus.in_score;
              sat_flag <= 1'b0;
            end else if (bus.in_score < min_r) begin
              min_r <= bus.in_score;
            end
            if (cnt == LAST) begin
              cnt          <= '0;
              state        <= S_EXP;
              bus.in_ready <= 1'b0;
              busy         <= 1'b1;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        S_EXP: begin
          lut_x      <= clamp_idx(diff_p0);
          cap_vld_p1 <= 1'b1;
          cap_idx_p1 <= cnt;
          if (is_clamped(diff_p0)) begin
            sat_flag <= 1'b1;
          end
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= S_OUT;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_OUT: begin
          if (!bus.out_valid) begin
            // First S_OUT cycle: the final LUT capture is still in flight, so beat 0 is presented one edge later.
            bus.out_valid <= 1'b1;
            bus.out_exp   <= exp_buf[cnt];
            bus.out_idx   <= cnt;
            bus.out_last  <= (cnt == LAST);
          end else if (bus.out_ready) begin
            if (bus.out_last) begin
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              cnt           <= '0;
              state         <= S_LOAD;
              bus.in_ready  <= 1'b1;
              busy          <= 1'b0;
            end else begin
              cnt          <= cnt + 4'd1;
              bus.out_exp  <= exp_buf[cnt + 4'd1];
              bus.out_idx  <= cnt + 4'd1;
              bus.out_last <= ((cnt + 4'd1) == LAST);
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule
